nthuee_scroll_ctrl: RTL and testbench
=====================================

// Module: nthuee_scroll_ctrl
// PURPOSE
//  Sequencer for the nthuee_14seg decoder on a 4-digit multiplexed 14-segment display.
//  Scrolls the message "NTHUEE" followed by 4 blanks right-to-left and time-multiplexes
//  the digit enables. Drives the decoder's 4-bit alphabet input and the active-low
//  digit-select lines; the decoder's 15-bit output goes straight to the segment pins.
// PARAMETERS
//  SCAN_DIV    50000     clk cycles per digit-scan step (>=2)
//  SCROLL_DIV  25000000  clk cycles per one-position scroll step (>=2)
//  MSG_LEN     10        ring length: 6 letters + 4 blanks (fixed; not user-varied)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  hold       in   1  1 = freeze scroll position; digit scanning continues
//  restart    in   1  sync 1-cycle pulse: scroll position -> 0, scroll counter -> 0
//  alphabet   out  4  code to nthuee_14seg (0..5 = N,T,H,U,E,E; 4'd15 = blank)
//  digit_sel  out  4  active-low digit enable, [3]=leftmost .. [0]=rightmost, one-cold
//  scroll_pos out  4  current ring position shown on the leftmost digit, 0..9
// BEHAVIOUR
//  - Ring: index k in 0..5 -> alphabet=k; k in 6..9 -> alphabet=4'd15 (decoder blanks).
//  - Scan counter sc: 0..SCAN_DIV-1, wraps; scan_tick when sc==SCAN_DIV-1.
//  - Digit index d (2 bits): d=0 leftmost .. d=3 rightmost; d increments mod 4 on scan_tick.
//  - Scroll counter rc: 0..SCROLL_DIV-1, wraps; scroll_tick when rc==SCROLL_DIV-1 and !hold.
//    While hold=1, rc and scroll_pos freeze (rc does not advance).
//  - scroll_pos increments mod 10 on scroll_tick (9 -> 0 wrap).
//  - Outputs registered: on the same edge that updates d/scroll_pos, digit_sel and
//    alphabet update together; digit_sel = ~(4'b1000 >> d_next);
//    alphabet = ring[(scroll_pos_next + d_next) mod 10]. Latency 1 clk from state change;
//    never a cycle where digit_sel and alphabet disagree.
//  - Sum (scroll_pos+d) uses 4-bit arithmetic, values 10..12 wrap by subtracting 10.
//  - restart: clears scroll_pos and rc next edge; takes priority over scroll_tick and hold;
//    does not touch sc or d. alphabet reflects new position on the same edge.
//  - Simultaneous scan_tick and scroll_tick: both applied on the same edge; outputs use
//    both new values.
//  - Reset (async, any time, incl. mid-scan): sc=0, rc=0, d=0, scroll_pos=0,
//    digit_sel=4'b0111, alphabet=4'd0 (N), scroll_pos output=0. Released reset: first
//    scan_tick after SCAN_DIV clk edges.
//  - Exactly one digit_sel bit low at all times after reset; no all-ones/multi-low glitch.
// TESTING  (SCAN_DIV=4, SCROLL_DIV=32 unless noted)
//  1 Reset: assert rst_n=0 mid-run -> immediately digit_sel=0111, alphabet=0, scroll_pos=0.
//  2 Scan: from reset, 16 clk -> digit_sel 0111,1011,1101,1110 each 4 clk; alphabet
//    0,1,2,3 (N,T,H,U); then repeats 0111/alphabet 0.
//  3 Scroll wrap: run 320 clk -> scroll_pos 0..9 then 0; at scroll_pos=7 digits show
//    ring 7,8,9,0 -> alphabet 15,15,15,0; at pos=4: 4,5,15,15.
//  4 hold: assert hold at scroll_pos=3 for 100 clk -> scroll_pos stays 3, digit_sel keeps
//    rotating; release -> next advance exactly 32-rc_frozen clk later.
//  5 restart on scroll_tick cycle with hold=1 -> scroll_pos=0, rc=0 next edge.
//  6 Invariant check every clk: digit_sel one-cold; alphabet in {0..5,15}.

Source files
------------

// File: rtl/nthuee_scroll_ctrl.sv
// Scroll/scan sequencer for a 4-digit multiplexed 14-segment display showing "NTHUEE".
// Produces the decoder alphabet code and the one-cold active-low digit select, both registered.
module nthuee_scroll_ctrl #(
    parameter int SCAN_DIV   = 50000,
    parameter int SCROLL_DIV = 25000000,
    parameter int MSG_LEN    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       restart,
    output logic [3:0] alphabet,
    output logic [3:0] digit_sel,
    output logic [3:0] scroll_pos
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SW-1:0] SC_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] RC_MAX  = RW'(SCROLL_DIV - 1);
    localparam logic [3:0]    POS_MAX = 4'(MSG_LEN - 1);
    localparam logic [3:0]    RING_N  = 4'(MSG_LEN);
    localparam logic [3:0]    LETTERS = 4'd6;
    localparam logic [3:0]    BLANK   = 4'd15;

    logic [SW-1:0] sc, sc_next;
    logic [RW-1:0] rc, rc_next;
    logic [1:0]    d, d_next;
    logic [3:0]    pos_next;
    logic [3:0]    sum_raw, ring_idx;
    logic [3:0]    alpha_next, sel_next;
    logic          scan_tick, scroll_tick;

    always_comb begin
        scan_tick   = (sc == SC_MAX);
        scroll_tick = (rc == RC_MAX) && !hold;

        sc_next = scan_tick ? '0 : sc + SW'(1);
        d_next  = scan_tick ? d + 2'd1 : d;

        // restart overrides both hold and a pending scroll tick
        rc_next  = rc;
        pos_next = scroll_pos;
        if (restart) begin
            rc_next  = '0;
            pos_next = 4'd0;
        end else if (!hold) begin
            rc_next = (rc == RC_MAX) ? '0 : rc + RW'(1);
            if (scroll_tick) begin
                pos_next = (scroll_pos == POS_MAX) ? 4'd0 : scroll_pos + 4'd1;
            end
        end

        // outputs are built from next-state values so select and code change together
        sum_raw    = pos_next + {2'b00, d_next};
        ring_idx   = (sum_raw >= RING_N) ? sum_raw - RING_N : sum_raw;
        alpha_next = (ring_idx < LETTERS) ? ring_idx : BLANK;
        sel_next   = ~(4'b1000 >> d_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc         <= '0;
            rc         <= '0;
            d          <= 2'd0;
            scroll_pos <= 4'd0;
            digit_sel  <= 4'b0111;
            alphabet   <= 4'd0;
        end else begin
            sc         <= sc_next;
            rc         <= rc_next;
            d          <= d_next;
            scroll_pos <= pos_next;
            digit_sel  <= sel_next;
            alphabet   <= alpha_next;
        end
    end

endmodule

// File: tb/tb_nthuee_scroll_ctrl.sv
// Directed self-checking bench for nthuee_scroll_ctrl with SCAN_DIV=4, SCROLL_DIV=32.
// Expected values come from edge counts since reset release and hand-written ring tables.
module tb_nthuee_scroll_ctrl;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic       restart;
    logic [3:0] alphabet;
    logic [3:0] digit_sel;
    logic [3:0] scroll_pos;

    int errors;
    int checks;
    int k;

    int         ring_tab [10] = '{0, 1, 2, 3, 4, 5, 15, 15, 15, 15};
    logic [3:0] sel_tab  [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    nthuee_scroll_ctrl #(
        .SCAN_DIV  (4),
        .SCROLL_DIV(32),
        .MSG_LEN   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .restart   (restart),
        .alphabet  (alphabet),
        .digit_sel (digit_sel),
        .scroll_pos(scroll_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariant monitor: one-cold select and a legal alphabet code on every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones(~digit_sel) != 1 || (alphabet > 4'd5 && alphabet != 4'd15)) begin
                errors++;
                $display("[TB] FAIL invariant: digit_sel=%b alphabet=%0d (need one-cold, code 0..5 or 15)",
                         digit_sel, alphabet);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic release_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        hold    = 1'b0;
        restart = 1'b0;
        release_reset();
        for (int i = 0; i < 45; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (digit_sel !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL reset_sel: got %b want 0111", digit_sel);
        end
        checks++;
        if (alphabet !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_alpha: got %0d want 0", alphabet);
        end
        checks++;
        if (scroll_pos !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_pos: got %0d want 0", scroll_pos);
        end
    endtask

    task automatic test_scan();
        int exp_d;
        release_reset();
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) tick();
            exp_d = (k / 4) % 4;
            checks++;
            if (digit_sel !== sel_tab[exp_d] || alphabet !== 4'(exp_d)) begin
                errors++;
                $display("[TB] FAIL scan k=%0d: sel=%b alpha=%0d want sel=%b alpha=%0d",
                         k, digit_sel, alphabet, sel_tab[exp_d], exp_d);
            end
        end
    endtask

    task automatic test_scroll_wrap();
        int exp_pos;
        int exp_d;
        int exp_a;
        while (k < 330) begin
            tick();
            exp_pos = (k / 32) % 10;
            exp_d   = (k / 4) % 4;
            exp_a   = ring_tab[(exp_pos + exp_d) % 10];
            checks++;
            if (scroll_pos !== 4'(exp_pos) || digit_sel !== sel_tab[exp_d] || alphabet !== 4'(exp_a)) begin
                errors++;
                $display("[TB] FAIL scroll k=%0d: pos=%0d sel=%b alpha=%0d want pos=%0d sel=%b alpha=%0d",
                         k, scroll_pos, digit_sel, alphabet, exp_pos, sel_tab[exp_d], exp_a);
            end
        end
    endtask

    task automatic test_hold();
        int exp_d;
        int exp_pos;
        release_reset();
        // pos=3 reached at edge 96; ten more edges leaves the scroll counter at 10
        while (k < 106) tick();
        hold = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_d = (k / 4) % 4;
            checks++;
            if (scroll_pos !== 4'd3 || digit_sel !== sel_tab[exp_d] || alphabet !== 4'(ring_tab[(3 + exp_d) % 10])) begin
                errors++;
                $display("[TB] FAIL hold k=%0d: pos=%0d sel=%b alpha=%0d want pos=3 sel=%b alpha=%0d",
                         k, scroll_pos, digit_sel, alphabet, sel_tab[exp_d], ring_tab[(3 + exp_d) % 10]);
            end
        end
        hold = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            tick();
            exp_pos = (i >= 22) ? 4 : 3;
            checks++;
            if (scroll_pos !== 4'(exp_pos)) begin
                errors++;
                $display("[TB] FAIL hold_release +%0d: pos=%0d want %0d", i, scroll_pos, exp_pos);
            end
        end
    endtask

    task automatic test_restart();
        int exp_pos;
        release_reset();
        // edge 63: pos=1 and scroll counter at its last value
        while (k < 63) tick();
        checks++;
        if (scroll_pos !== 4'd1) begin
            errors++;
            $display("[TB] FAIL restart_pre: pos=%0d want 1", scroll_pos);
        end
        hold    = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        hold    = 1'b0;
        checks++;
        if (scroll_pos !== 4'd0 || alphabet !== 4'd0 || digit_sel !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL restart_edge: pos=%0d alpha=%0d sel=%b want pos=0 alpha=0 sel=0111",
                     scroll_pos, alphabet, digit_sel);
        end
        for (int i = 1; i <= 33; i++) begin
            tick();
            exp_pos = (i >= 32) ? 1 : 0;
            checks++;
            if (scroll_pos !== 4'(exp_pos)) begin
                errors++;
                $display("[TB] FAIL restart_rc +%0d: pos=%0d want %0d", i, scroll_pos, exp_pos);
            end
        end
    endtask

    task automatic test_back_to_back();
        // restart pulses on consecutive cycles keep pos at 0 while scanning continues
        restart = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (scroll_pos !== 4'd0 || digit_sel !== sel_tab[(k / 4) % 4]) begin
                errors++;
                $display("[TB] FAIL back_to_back k=%0d: pos=%0d sel=%b want pos=0 sel=%b",
                         k, scroll_pos, digit_sel, sel_tab[(k / 4) % 4]);
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        k       = 0;
        rst_n   = 1'b0;
        hold    = 1'b0;
        restart = 1'b0;
        #12;
        test_reset();
        test_scan();
        test_scroll_wrap();
        test_hold();
        test_restart();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
